// File: rtl/ssm_state_update_fp16.sv
// SSM recurrence h_new = dA*h_prev + (dt*x)*B over all (b,h,p,n) elements, one element
// issued per cycle through a 3-stage FP16 multiply/multiply/add pipeline.

package ssm_fp16_pkg;
  // Round-to-nearest-even pack; denormal results flush to signed zero.
  function automatic logic [15:0] fp16_pack(input logic s, input int e, input logic [9:0] m,
                                            input logic g, input logic st);
    logic [10:0] mr;
    int          er;
    mr = {1'b0, m} + {10'b0, g & (st | m[0])};
    er = mr[10] ? e + 1 : e;
    if (er >= 31) return {s, 5'h1f, 10'h000};
    if (er <= 0)  return {s, 15'h0000};
    return {s, er[4:0], mr[9:0]};
  endfunction

  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic [21:0] prod;
    int          e;
    s = a[15] ^ b[15];
    if ((&a[14:10] & |a[9:0]) | (&b[14:10] & |b[9:0])) return 16'h7e00;
    if (&a[14:10] | &b[14:10])
      return (a[14:10] == 5'h00 || b[14:10] == 5'h00) ? 16'h7e00 : {s, 5'h1f, 10'h000};
    if (a[14:10] == 5'h00 || b[14:10] == 5'h00) return {s, 15'h0000};
    prod = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
    e    = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (prod[21]) return fp16_pack(s, e + 1, prod[20:11], prod[10], |prod[9:0]);
    return fp16_pack(s, e, prod[19:10], prod[9], |prod[8:0]);
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] big, sml;
    logic [27:0] mb, ms, sum, nrm;
    logic [4:0]  d;
    int          sh;
    if ((&a[14:10] & |a[9:0]) | (&b[14:10] & |b[9:0])) return 16'h7e00;
    if (&a[14:10] & &b[14:10]) return (a[15] == b[15]) ? a : 16'h7e00;
    if (&a[14:10]) return a;
    if (&b[14:10]) return b;
    if (a[14:10] == 5'h00 && b[14:10] == 5'h00) return {a[15] & b[15], 15'h0000};
    if (a[14:10] == 5'h00) return b;
    if (b[14:10] == 5'h00) return a;
    if (a[14:0] >= b[14:0]) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    // 16 spare low bits keep alignment lossless; farther operands only contribute sticky
    d   = big[14:10] - sml[14:10];
    mb  = {2'b01, big[9:0], 16'h0000};
    ms  = (d > 5'd16) ? 28'd1 : ({2'b01, sml[9:0], 16'h0000} >> d);
    sum = (a[15] == b[15]) ? mb + ms : mb - ms;
    if (sum == 28'd0) return 16'h0000;
    sh = 0;
    for (int i = 0; i < 28; i++) if (sum[i]) sh = 27 - i;
    nrm = sum << sh;
    return fp16_pack(big[15], int'(big[14:10]) + 1 - sh, nrm[26:17], nrm[16], |nrm[15:0]);
  endfunction
endpackage

module fp16_mult_wrapper #(parameter int LAT = 6) (
  input  logic        clk,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        valid_in,
  output logic [15:0] result,
  output logic        valid_out
);
  import ssm_fp16_pkg::*;
  logic [LAT-1:0][15:0] pipe;
  logic [LAT-1:0]       vpipe;
  always_ff @(posedge clk) begin
    pipe[0]  <= fp16_mul(a, b);
    vpipe[0] <= valid_in;
    for (int i = 1; i < LAT; i++) begin
      pipe[i]  <= pipe[i-1];
      vpipe[i] <= vpipe[i-1];
    end
  end
  assign result    = pipe[LAT-1];
  assign valid_out = vpipe[LAT-1];
endmodule

module fp16_add_wrapper #(parameter int LAT = 11) (
  input  logic        clk,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        valid_in,
  output logic [15:0] result,
  output logic        valid_out
);
  import ssm_fp16_pkg::*;
  logic [LAT-1:0][15:0] pipe;
  logic [LAT-1:0]       vpipe;
  always_ff @(posedge clk) begin
    pipe[0]  <= fp16_add(a, b);
    vpipe[0] <= valid_in;
    for (int i = 1; i < LAT; i++) begin
      pipe[i]  <= pipe[i-1];
      vpipe[i] <= vpipe[i-1];
    end
  end
  assign result    = pipe[LAT-1];
  assign valid_out = vpipe[LAT-1];
endmodule

module ssm_state_update_fp16 #(
  parameter int B     = 1,
  parameter int H     = 2,
  parameter int P     = 2,
  parameter int N     = 4,
  parameter int DW    = 16,
  parameter int M_LAT = 6,
  parameter int A_LAT = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [B*H*P*N*DW-1:0]   h_prev_flat,
  input  logic [B*H*DW-1:0]       dA_flat,
  input  logic [B*H*DW-1:0]       dt_flat,
  input  logic [B*H*P*DW-1:0]     x_flat,
  input  logic [B*N*DW-1:0]       B_flat,
  output logic [B*H*P*N*DW-1:0]   h_new_flat,
  output logic                    busy,
  output logic                    done
);
  localparam int D  = 2*M_LAT + A_LAT;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam int HW = (H > 1) ? $clog2(H) : 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  typedef struct packed {
    logic [BW-1:0] b;
    logic [HW-1:0] h;
    logic [PW-1:0] p;
    logic [NW-1:0] n;
  } tag_t;

  localparam tag_t LAST = '{b: BW'(B-1), h: HW'(H-1), p: PW'(P-1), n: NW'(N-1)};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  function automatic int bh_idx(input tag_t t);
    return int'(t.b)*H + int'(t.h);
  endfunction

  function automatic int elem_idx(input tag_t t);
    return (bh_idx(t)*P + int'(t.p))*N + int'(t.n);
  endfunction

  state_t                  state, nxt;
  tag_t                    cnt;
  tag_t [D:0]              tag_pipe;
  logic [D:0]              vld_pipe;
  logic [DW-1:0]           op_da, op_h, op_dt, op_x;
  logic [M_LAT-1:0][DW-1:0] ah_dly;
  logic [DW-1:0]           p_ah, p_dtx, p_m2, sum, b_op;
  logic                    v_ah, v_dtx, v_m2, v_sum, wr_en, wr_last;

  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE:  if (start) nxt = ISSUE;
      ISSUE: begin
        busy = 1'b1;
        if (cnt == LAST) nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (wr_last) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Index 0 of the valid/tag pipes travels with the stage-1 operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tag_pipe   <= '0;
      vld_pipe   <= '0;
      op_da      <= '0;
      op_h       <= '0;
      op_dt      <= '0;
      op_x       <= '0;
      ah_dly     <= '0;
      h_new_flat <= '0;
      wr_last    <= 1'b0;
    end else begin
      state    <= nxt;
      vld_pipe <= {vld_pipe[D-1:0], state == ISSUE};
      tag_pipe <= {tag_pipe[D-1:0], cnt};
      ah_dly   <= {ah_dly[M_LAT-2:0], p_ah};
      wr_last  <= wr_en && (tag_pipe[D] == LAST);
      if (state == IDLE && start) begin
        cnt <= '0;
      end else if (state == ISSUE) begin
        op_da <= dA_flat[bh_idx(cnt)*DW +: DW];
        op_dt <= dt_flat[bh_idx(cnt)*DW +: DW];
        op_x  <= x_flat[(bh_idx(cnt)*P + int'(cnt.p))*DW +: DW];
        op_h  <= h_prev_flat[elem_idx(cnt)*DW +: DW];
        if (cnt.n == NW'(N-1)) begin
          cnt.n <= '0;
          if (cnt.p == PW'(P-1)) begin
            cnt.p <= '0;
            if (cnt.h == HW'(H-1)) begin
              cnt.h <= '0;
              cnt.b <= (cnt.b == BW'(B-1)) ? '0 : cnt.b + 1'b1;
            end else cnt.h <= cnt.h + 1'b1;
          end else cnt.p <= cnt.p + 1'b1;
        end else cnt.n <= cnt.n + 1'b1;
      end
      if (wr_en) h_new_flat[elem_idx(tag_pipe[D])*DW +: DW] <= sum;
    end
  end

  assign b_op  = B_flat[(int'(tag_pipe[M_LAT].b)*N + int'(tag_pipe[M_LAT].n))*DW +: DW];
  // Wrapper valids carry no reset, so the tag valid is what actually permits a write.
  assign wr_en = vld_pipe[D] & v_sum;

  fp16_mult_wrapper #(.LAT(M_LAT)) u_mul_ah (
    .clk(clk), .a(op_da), .b(op_h), .valid_in(vld_pipe[0]), .result(p_ah), .valid_out(v_ah));

  fp16_mult_wrapper #(.LAT(M_LAT)) u_mul_dtx (
    .clk(clk), .a(op_dt), .b(op_x), .valid_in(vld_pipe[0]), .result(p_dtx), .valid_out(v_dtx));

  fp16_mult_wrapper #(.LAT(M_LAT)) u_mul_b (
    .clk(clk), .a(p_dtx), .b(b_op), .valid_in(v_dtx & v_ah & vld_pipe[M_LAT]),
    .result(p_m2), .valid_out(v_m2));

  fp16_add_wrapper #(.LAT(A_LAT)) u_add (
    .clk(clk), .a(p_m2), .b(ah_dly[M_LAT-1]), .valid_in(v_m2 & vld_pipe[2*M_LAT]),
    .result(sum), .valid_out(v_sum));
endmodule
